// File: rtl/uart_fifo_interface.sv
// -----------------------------------------------------------------------------
// uart_fifo_interface
//   Buffered UART between the 6809 bus decode and the FT2232 serial pins.
//   Single clock domain, mid-bit RX sampling, runtime 5..8 data bits,
//   RX/TX FIFOs, sticky error flags and two level interrupt sources.
//
// Parameters
//   CLOCK_DIVISOR  clk cycles per serial bit (>= 4)
//   DATA_BITS      maximum frame width; runtime width = 5 + control[5:4], capped
//   FIFO_DEPTH     entries per FIFO, power of two, 2..256
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   i_RW                1 = CPU read, 0 = CPU write
//   i_uart_data_ce      data register select
//   i_uart_control_ce   control register select
//   i_control[7:0]      control write data
//   i_uart_rxdata[7:0]  CPU write data, pushed into the TX FIFO
//   i_UART_TX           serial line from the FT2232 (asynchronous)
//   o_UART_RX           serial line to the FT2232, idles high
//   o_uart_txdata[7:0]  RX FIFO head returned to the CPU
//   o_uart_status[7:0]  status register
//   o_control[7:0]      control readback
//   o_IRQ               active-low interrupt
//
// Configuration
//   UART_PARITY_EN  when defined, a parity bit (even, or odd with control[6])
//                   follows the data bits in both directions.
// -----------------------------------------------------------------------------
module uart_fifo_interface #(
  parameter int CLOCK_DIVISOR = 9236,
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_RW,
  input  logic       i_uart_data_ce,
  input  logic       i_uart_control_ce,
  input  logic [7:0] i_control,
  input  logic [7:0] i_uart_rxdata,
  input  logic       i_UART_TX,
  output logic       o_UART_RX,
  output logic [7:0] o_uart_txdata,
  output logic [7:0] o_uart_status,
  output logic [7:0] o_control,
  output logic       o_IRQ
);

  localparam int CNT_W = $clog2(CLOCK_DIVISOR);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCK_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCK_DIVISOR / 2 - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // CPU access decode: one access per rising edge of a chip enable
  // ---------------------------------------------------------------------------
  logic data_ce_q, control_ce_q;
  logic data_wr, data_rd, ctrl_wr, flush;
  logic [7:0] control_q;

  assign data_wr = i_uart_data_ce & ~data_ce_q & ~i_RW;
  assign data_rd = i_uart_data_ce & ~data_ce_q & i_RW;
  assign ctrl_wr = i_uart_control_ce & ~control_ce_q & ~i_RW;
  assign flush   = ctrl_wr & i_control[7];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ce_q    <= 1'b0;
      control_ce_q <= 1'b0;
      control_q    <= 8'h00;
    end else begin
      data_ce_q    <= i_uart_data_ce;
      control_ce_q <= i_uart_control_ce;
      if (ctrl_wr)
        control_q <= {1'b0, i_control[6:0]};  // flush bit is a one-shot command
    end
  end

  assign o_control = control_q;

  logic [3:0] frame_width;
  always_comb begin
    frame_width = 4'd5 + {2'b00, control_q[5:4]};
    if (frame_width > 4'(DATA_BITS))
      frame_width = 4'(DATA_BITS);
  end

  logic [DATA_BITS-1:0] width_mask;
  assign width_mask = (DATA_BITS'(1) << frame_width) - DATA_BITS'(1);

  // ---------------------------------------------------------------------------
  // FIFOs: natural-wrap pointers, occupancy from a separate count
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_done;
  logic [DATA_BITS-1:0] rx_data;

  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign tx_push  = data_wr & ~tx_full;
  assign rx_pop   = data_rd & ~rx_empty;
  assign rx_push  = rx_done & ~rx_full;

  // NOTE: the storage arrays carry no reset; the counts alone define validity,
  // and leaving memories unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= i_uart_rxdata[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      o_uart_txdata <= 8'h00;
    else if (data_rd)
      o_uart_txdata <= rx_empty ? 8'h00 : 8'(rx_mem[rx_rd_ptr]);
  end

  // ---------------------------------------------------------------------------
  // TX shifter
  // ---------------------------------------------------------------------------
  tx_state_t tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0] tx_bit, tx_bit_n, tx_width_q;
  logic [DATA_BITS-1:0] tx_shift, tx_head;
  logic tx_tick, tx_line_n, tx_shift_en;
`ifdef UART_PARITY_EN
  logic tx_par_q;
`endif

  assign tx_tick = (tx_cnt == BIT_LAST);
  assign tx_head = tx_mem[tx_rd_ptr] & width_mask;

  // NOTE: every output of this block is defaulted first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    tx_state_n  = tx_state;
    tx_line_n   = o_UART_RX;
    tx_bit_n    = tx_bit;
    tx_pop      = 1'b0;
    tx_shift_en = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_tick) begin
        tx_line_n   = tx_shift[0];
        tx_shift_en = 1'b1;
        tx_bit_n    = 4'd0;
        tx_state_n  = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit == tx_width_q - 4'd1) begin
`ifdef UART_PARITY_EN
          tx_line_n  = tx_par_q;
          tx_state_n = TX_PARITY;
`else
          tx_line_n  = 1'b1;
          tx_state_n = TX_STOP;
`endif
        end else begin
          tx_line_n   = tx_shift[0];
          tx_shift_en = 1'b1;
          tx_bit_n    = tx_bit + 4'd1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) begin
        tx_line_n  = 1'b1;
        tx_state_n = TX_STOP;
      end
`endif
      TX_STOP: if (tx_tick) begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= 4'd0;
      tx_shift   <= '0;
      tx_width_q <= 4'd0;
      o_UART_RX  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state  <= tx_state_n;
      tx_bit    <= tx_bit_n;
      o_UART_RX <= tx_line_n;
      tx_cnt    <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_pop) begin
        // Width and parity sense are frozen at the start bit.
        tx_shift   <= tx_head;
        tx_width_q <= frame_width;
`ifdef UART_PARITY_EN
        tx_par_q   <= (^tx_head) ^ control_q[6];
`endif
      end else if (tx_shift_en) begin
        tx_shift <= tx_shift >> 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX deserialiser
  // ---------------------------------------------------------------------------
  rx_state_t rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0] rx_bit, rx_width_q;
  logic rx_meta, rx_line, rx_line_q, rx_fall, rx_tick, rx_begin, rx_store;
`ifdef UART_PARITY_EN
  logic rx_odd_q, rx_par_chk;
`endif

  assign rx_fall = rx_line_q & ~rx_line;
  // The start bit is qualified at half a bit, every later sample a full bit on.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_n = rx_state;
    rx_begin   = 1'b0;
    rx_store   = 1'b0;
    rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_chk = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_begin   = 1'b1;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_tick)
        rx_state_n = rx_line ? RX_IDLE : RX_DATA;  // high again: glitch
      RX_DATA: if (rx_tick) begin
        rx_store = 1'b1;
        if (rx_bit == rx_width_q - 4'd1)
`ifdef UART_PARITY_EN
          rx_state_n = RX_PARITY;
`else
          rx_state_n = RX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_tick) begin
        rx_par_chk = 1'b1;
        rx_state_n = RX_STOP;
      end
`endif
      RX_STOP: if (rx_tick) begin
        rx_done    = 1'b1;
        rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_line    <= 1'b1;
      rx_line_q  <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= 4'd0;
      rx_data    <= '0;
      rx_width_q <= 4'd0;
`ifdef UART_PARITY_EN
      rx_odd_q   <= 1'b0;
`endif
    end else begin
      rx_meta   <= i_UART_TX;
      rx_line   <= rx_meta;
      rx_line_q <= rx_line;
      rx_state  <= rx_state_n;
      rx_cnt    <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_begin) begin
        rx_data    <= '0;
        rx_bit     <= 4'd0;
        rx_width_q <= frame_width;
`ifdef UART_PARITY_EN
        rx_odd_q   <= control_q[6];
`endif
      end else if (rx_store) begin
        rx_data <= rx_data | (DATA_BITS'(rx_line) << rx_bit);
        rx_bit  <= rx_bit + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags, interrupt and status
  // ---------------------------------------------------------------------------
  logic overrun_q, frame_err_q, tx_drop_q, par_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_drop_q   <= 1'b0;
      o_IRQ       <= 1'b1;
    end else begin
      // A new error in the same cycle as the clearing write wins.
      if (ctrl_wr) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (rx_done && rx_full)     overrun_q   <= 1'b1;
      if (rx_done && !rx_line)    frame_err_q <= 1'b1;
      if (data_wr && tx_full)     tx_drop_q   <= 1'b1;
      o_IRQ <= ~((control_q[0] & ~rx_empty) |
                 (control_q[1] & tx_empty & (tx_state == TX_IDLE)));
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)
      par_err_q <= 1'b0;
    else if (rx_par_chk && ((^rx_data ^ rx_line) != rx_odd_q))
      par_err_q <= 1'b1;
  end
`else
  assign par_err_q = 1'b0;
`endif

  assign o_uart_status = {~o_IRQ, tx_drop_q, par_err_q, frame_err_q, overrun_q,
                          tx_full, ~tx_empty | (tx_state != TX_IDLE), ~rx_empty};

endmodule

// File: tb/tb_uart_fifo_interface.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_interface
//   Directed-plus-random bench for uart_fifo_interface. A behavioural model
//   (byte queues and sticky flags) predicts the RX FIFO contents, the frames
//   expected on the serial output and the status register. A background
//   monitor decodes frames from o_UART_RX.
// -----------------------------------------------------------------------------
module tb_uart_fifo_interface;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_RW, i_uart_data_ce, i_uart_control_ce, i_UART_TX;
  logic [7:0] i_control, i_uart_rxdata;
  logic       o_UART_RX, o_IRQ;
  logic [7:0] o_uart_txdata, o_uart_status, o_control;

  uart_fifo_interface #(
    .CLOCK_DIVISOR(DIV),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_RW             (i_RW),
    .i_uart_data_ce   (i_uart_data_ce),
    .i_uart_control_ce(i_uart_control_ce),
    .i_control        (i_control),
    .i_uart_rxdata    (i_uart_rxdata),
    .i_UART_TX        (i_UART_TX),
    .o_UART_RX        (o_UART_RX),
    .o_uart_txdata    (o_uart_txdata),
    .o_uart_status    (o_uart_status),
    .o_control        (o_control),
    .o_IRQ            (o_IRQ)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic [7:0] data;
    logic       stop;
  } frame_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] m_ctrl;
  logic       m_ovr, m_ferr, m_drop;
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  frame_t     seen[$];
  int         mon_width = 8;
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input logic [7:0] ctrl);
    int w = 5 + int'(ctrl[5:4]);
    return (w > 8) ? 8 : w;
  endfunction

  function automatic logic [7:0] wmask(input int w);
    return 8'((1 << w) - 1);
  endfunction

  // Status as seen with the transmitter idle.
  function automatic logic [7:0] m_status();
    logic rxne = (rx_q.size() != 0);
    logic irq  = (m_ctrl[0] & rxne) | m_ctrl[1];
    return {irq, m_drop, 1'b0, m_ferr, m_ovr, 1'b0, 1'b0, rxne};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    @(negedge clk);
    i_RW = 1'b0; i_control = v; i_uart_control_ce = 1'b1;
    @(negedge clk);
    i_uart_control_ce = 1'b0;
    m_ctrl = {1'b0, v[6:0]};
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    mon_width = width_of(m_ctrl);
    check("ctrl_readback", o_control, m_ctrl);
  endtask

  task automatic write_data(input logic [7:0] v);
    @(negedge clk);
    i_RW = 1'b0; i_uart_rxdata = v; i_uart_data_ce = 1'b1;
    @(negedge clk);
    i_uart_data_ce = 1'b0;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    i_RW = 1'b1; i_uart_data_ce = 1'b1;
    @(negedge clk);
    i_uart_data_ce = 1'b0; i_RW = 1'b0;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    check(tag, o_uart_txdata, exp);
  endtask

  task automatic send_serial(input logic [7:0] v, input logic stop_bit);
    int w = width_of(m_ctrl);
    i_UART_TX = 1'b0;
    cycles(DIV);
    for (int i = 0; i < w; i++) begin
      i_UART_TX = v[i];
      cycles(DIV);
    end
    i_UART_TX = stop_bit;
    cycles(DIV);
    i_UART_TX = 1'b1;
    cycles(2);
    if (rx_q.size() < DEPTH) rx_q.push_back(v & wmask(w));
    else                     m_ovr = 1'b1;
    if (!stop_bit) m_ferr = 1'b1;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (o_uart_status[1] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, o_uart_status[1], 1'b0);
  endtask

  task automatic compare_tx(input string tag);
    frame_t f;
    logic [7:0] e;
    wait_tx_idle({tag, "_drain"});
    check({tag, "_frame_count"}, seen.size(), tx_exp.size());
    while (tx_exp.size() != 0 && seen.size() != 0) begin
      f = seen.pop_front();
      e = tx_exp.pop_front();
      check({tag, "_start"}, f.start, 1'b0);
      check({tag, "_data"},  f.data,  e);
      check({tag, "_stop"},  f.stop,  1'b1);
    end
    seen.delete();
    tx_exp.delete();
  endtask

  // Serial output monitor: samples each bit at its midpoint.
  initial begin
    frame_t f;
    wait (mon_en);
    forever begin
      @(negedge o_UART_RX);
      repeat (DIV / 2) @(posedge clk);
      #1 f.start = o_UART_RX;
      f.data = 8'h00;
      for (int i = 0; i < mon_width; i++) begin
        repeat (DIV) @(posedge clk);
        #1 f.data[i] = o_UART_RX;
      end
      repeat (DIV) @(posedge clk);
      #1 f.stop = o_UART_RX;
      seen.push_back(f);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;

    reset = 1'b1; i_RW = 1'b0; i_uart_data_ce = 1'b0; i_uart_control_ce = 1'b0;
    i_control = 8'h00; i_uart_rxdata = 8'h00; i_UART_TX = 1'b1;
    m_ctrl = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
    cycles(4);
    reset = 1'b0;
    cycles(1);
    mon_en = 1'b1;

    // Reset state
    check("rst_tx_line", o_UART_RX, 1'b1);
    check("rst_irq",     o_IRQ, 1'b1);
    check("rst_txdata",  o_uart_txdata, 8'h00);
    check("rst_status",  o_uart_status, 8'h00);
    check("rst_control", o_control, 8'h00);

    // 8-bit TX of 0x55: exact start-bit length, frame bits, busy flag
    write_ctrl(8'h30);
    write_data(8'h55);
    tx_exp.push_back(8'h55);
    check("tx55_busy", o_uart_status[1], 1'b1);
    n = 0;
    while (o_UART_RX !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (o_UART_RX === 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("tx55_start_len", n, DIV);
    compare_tx("tx55");

    // RX of 0xA3
    send_serial(8'hA3, 1'b1);
    check("rxA3_not_empty", o_uart_status[0], 1'b1);
    read_check("rxA3_data");
    check("rxA3_empty", o_uart_status[0], 1'b0);

    // TX FIFO overflow while the shifter holds the first byte
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      write_data(b);
      if (i < DEPTH + 1) tx_exp.push_back(b);
      else               m_drop = 1'b1;
    end
    check("txovf_full", o_uart_status[2], 1'b1);
    check("txovf_drop", o_uart_status[6], m_drop);
    compare_tx("txovf");

    // RX overrun, then cleared by a control write
    for (int i = 0; i < DEPTH + 1; i++) send_serial(8'($urandom), 1'b1);
    check("ovr_set", o_uart_status[3], m_ovr);
    write_ctrl(8'h30);
    check("ovr_clear", o_uart_status[3], 1'b0);
    for (int i = 0; i < DEPTH; i++) read_check("ovr_data");
    cycles(2);
    check("ovr_status", o_uart_status, m_status());

    // RX interrupt
    write_ctrl(8'h31);
    send_serial(8'h3C, 1'b1);
    check("irq_assert", o_IRQ, 1'b0);
    check("irq_status7", o_uart_status[7], 1'b1);
    read_check("irq_data");
    n = 0;
    while (o_IRQ !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    check("irq_release", o_IRQ, 1'b1);

    // TX-empty interrupt
    write_ctrl(8'h32);
    cycles(2);
    check("txe_irq", o_uart_status, m_status());
    write_ctrl(8'h30);
    cycles(2);
    check("txe_irq_off", o_IRQ, 1'b1);

    // 5-bit frames both ways
    write_ctrl(8'h00);
    write_data(8'h1F);
    tx_exp.push_back(8'h1F);
    compare_tx("w5_tx");
    send_serial(8'hF6, 1'b1);
    read_check("w5_rx");

    // Quarter-bit start glitch is rejected
    i_UART_TX = 1'b0;
    cycles(DIV / 4);
    i_UART_TX = 1'b1;
    cycles(3 * DIV);
    check("glitch", o_uart_status[0], 1'b0);

    // Framing error: frame stored, flag sticky until a control write
    write_ctrl(8'h30);
    b = 8'($urandom);
    send_serial(b, 1'b0);
    cycles(2);
    check("ferr_status", o_uart_status, m_status());
    read_check("ferr_data");
    write_ctrl(8'h30);
    check("ferr_clear", o_uart_status[4], 1'b0);

    // Random widths and bytes, both directions
    for (int k = 0; k < 6; k++) begin
      write_ctrl({2'b00, 2'($urandom_range(0, 3)), 4'h0});
      b = 8'($urandom);
      send_serial(b, 1'b1);
      read_check($sformatf("rnd%0d_rx", k));
      b = 8'($urandom);
      write_data(b);
      tx_exp.push_back(b & wmask(width_of(m_ctrl)));
      compare_tx($sformatf("rnd%0d_tx", k));
    end

    // Flush: in-flight frame completes, queued bytes vanish
    write_ctrl(8'h30);
    b = 8'($urandom);
    write_data(b);
    tx_exp.push_back(b);
    write_data(8'($urandom));
    write_data(8'($urandom));
    write_ctrl(8'hB0);
    cycles(1);
    check("flush_shifter_busy", o_uart_status[1], 1'b1);
    compare_tx("flush");
    cycles(2);
    check("flush_status", o_uart_status, m_status());

    // Reset in the middle of a frame releases the line on the next clock
    write_data(8'h00);
    cycles(3 * DIV);
    check("midrst_line_low", o_UART_RX, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_line_high", o_UART_RX, 1'b1);
    cycles(1);
    reset = 1'b0;
    m_ctrl = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
    rx_q.delete();
    cycles(1);
    check("midrst_status",  o_uart_status, 8'h00);
    check("midrst_control", o_control, 8'h00);
    check("midrst_txdata",  o_uart_txdata, 8'h00);
    check("midrst_irq",     o_IRQ, 1'b1);
    cycles(12 * DIV);
    seen.delete();
    tx_exp.delete();

    write_ctrl(8'h30);
    write_data(8'hC5);
    tx_exp.push_back(8'hC5);
    compare_tx("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
